spot_tracker: RTL and testbench
===============================

# spot_tracker

Streaming bright-spot tracker for the pen camera path: thresholds a pixel stream synchronised to the system clock and groups above-threshold horizontal runs into up to N_SPOTS bounding boxes per frame. At each frame boundary it latches the results into a read bank for the MCU-side data path. It generalises the single-spot search to a configurable spot count, pixel width and image size, with a runtime threshold.

## Interface

Parameters:
- PIX_W, 8, pixel bit width
- X_W, 10, column counter width
- Y_W, 10, row counter width
- N_SPOTS, 4, maximum tracked spots per frame (1..8)
- MIN_RUN, 2, minimum run length in pixels; shorter runs are dropped

Ports:
- clk  in  1  system clock
- nRst  in  1  reset, synchronous, active-low
- vsync  in  1  frame boundary, active-high; the rising edge ends the frame
- hsync  in  1  high while a line is active
- pix_valid  in  1  qualifies pix
- pix  in  PIX_W  pixel intensity
- thresh  in  PIX_W  a pixel is bright when pix >= thresh; sampled per pixel
- rd_addr  in  3+3  {spot index[5:3], field[2:0]}
- rd_data  out  16  registered read data, zero-extended
- spot_cnt  out  4  spots in the latched bank
- overflow  out  1  latched frame had more than N_SPOTS spots
- frame_done  out  1  one-cycle pulse after the bank update

## Operation

- **Counters.**
  - x resets to 0 on the hsync rising edge and increments per pix_valid while hsync is high.
  - y resets to 0 on the vsync rising edge and increments on the hsync falling edge.
  - Both saturate at all-ones.
- **Run detection.**
  - A run opens on the first bright valid pixel; xs = x.
  - It closes on the first dark valid pixel or on the hsync falling edge; xe = last bright x.
  - A run shorter than MIN_RUN is discarded.
- **Merge.** One cycle after a run closes, it is compared with all working slots in parallel. A slot i matches when all of the following hold:
  - it is valid;
  - ymax_i + 1 >= y;
  - xs <= xmax_i + 1;
  - xe + 1 >= xmin_i.
  - Lowest-index match wins: xmin = min, xmax = max, ymax = y.
  - No match: allocate the lowest free slot with xmin = xs, xmax = xe, ymin = ymax = y.
  - No match and no free slot: set the working overflow flag; the run is dropped.
  - Slots are never merged with each other.
- **Frame latch (vsync rising edge).**
  - The working slots, count and overflow flag are copied to the read bank.
  - The working set is then cleared.
  - frame_done pulses on the next cycle.
  - A run still open at vsync is discarded.
  - A merge scheduled in the same cycle is discarded and is not latched.
- **Readout fields.**
  - 0 = xmin, 1 = xmax, 2 = ymin, 3 = ymax, 4 = area (see Configuration), 5–7 = 0.
  - Spot index >= spot_cnt reads 0.
- **Reset.**
  - While nRst = 0 at a clock edge: all slots invalid, both banks zero, rd_data = 0, spot_cnt = 0, overflow = 0, frame_done = 0, counters 0, no open run.
  - A reset mid-frame loses the frame; no frame_done is generated.

## Timing

- Compare stage registered: a pixel affects run state 1 cycle after it is sampled.
- Merge completes 1 cycle after the run closes.
- Runs are separated by at least one dark pixel, so at most one merge is needed per 2 cycles; no queue.
- rd_data is valid 1 cycle after rd_addr. The read bank changes only at the frame latch.
- spot_cnt and overflow update in the same cycle as the bank, 1 cycle before frame_done.
- Simultaneous hsync falling and vsync rising: the vsync handling wins and the open run is discarded.
- Widths:
  - xmin, xmax: X_W bits; ymin, ymax: Y_W bits.
  - Adjacency compares use X_W+1 / Y_W+1 bits, so there is no wrap at 0 or at max.

## Configuration

- SPOT_AREA_EN defined: each slot also holds a 16-bit bright-pixel count.
  - The count is incremented by the run length on merge or allocation and saturates at 0xFFFF.
  - It is readable at field 4.
- SPOT_AREA_EN undefined: no area registers are built; field 4 reads 0.

## Test plan

- **Single spot.** Bright 4×3 block at x = 10..13, y = 5..7, thresh = 200, pix = 255 inside and 0 outside, then vsync.
  - frame_done pulse; spot_cnt = 1.
  - Fields 0–3 read 10, 13, 5, 7.
  - Field 4 reads 12 with SPOT_AREA_EN, 0 without.
- **Short run.** Single bright pixel with MIN_RUN = 2, then vsync: spot_cnt = 0, overflow = 0.
- **Overflow.** Five separated 2×2 blocks with N_SPOTS = 4, then vsync: spot_cnt = 4, overflow = 1; slot 3 holds the fourth block.
- **Diagonal adjacency.** Row 0 run x = 8..9, row 1 run x = 10..11: one spot, xmin = 8, xmax = 11.
- **Reset mid-frame.** nRst low for 1 cycle mid-frame, then a full frame with one spot.
  - Outputs are zero after the reset.
  - No frame_done for the interrupted frame.
  - The next frame reports spot_cnt = 1.
- **Bank stability.** Read spot 0 while the next frame streams: rd_data is unchanged until the vsync latch.

Source files
------------

// File: rtl/spot_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : spot_tracker_if
//  Brief    : Pixel-stream / readout bundle for the bright-spot tracker.
//             master = stream source and MCU reader, slave = tracker.
//  Revision : 1.0  initial release
// ============================================================================
interface spot_tracker_if #(
    parameter int PIX_W = 8
);
    logic             vsync;
    logic             hsync;
    logic             pix_valid;
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] thresh;
    logic [5:0]       rd_addr;
    logic [15:0]      rd_data;
    logic [3:0]       spot_cnt;
    logic             overflow;
    logic             frame_done;

    modport master (
        output vsync, hsync, pix_valid, pix, thresh, rd_addr,
        input  rd_data, spot_cnt, overflow, frame_done
    );

    modport slave (
        input  vsync, hsync, pix_valid, pix, thresh, rd_addr,
        output rd_data, spot_cnt, overflow, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/spot_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : spot_tracker
//  Brief    : Thresholds a pixel stream, groups bright horizontal runs into
//             up to N_SPOTS bounding boxes per frame and latches them into a
//             read bank on the vsync rising edge.
//             Optional feature macro: SPOT_AREA_EN (per-spot 16-bit pixel
//             count readable at field 4).
//  Revision : 1.0  initial release
// ============================================================================
module spot_tracker #(
    parameter int PIX_W   = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int N_SPOTS = 4,
    parameter int MIN_RUN = 2
) (
    input  logic         clk,
    input  logic         nRst,
    spot_tracker_if.slave bus
);

    localparam logic [X_W:0] C_MIN_RUN = MIN_RUN[X_W:0];

    // ------------------------------------------------------------------
    // Edge detection and x/y counters
    // ------------------------------------------------------------------
    logic           hs_q, vs_q;
    logic           w_hs_rise, w_hs_fall, w_vs_rise;
    logic [X_W-1:0] x_q, x_d, w_pix_x;
    logic [Y_W-1:0] y_q, y_d;

    assign w_hs_rise = bus.hsync & ~hs_q;
    assign w_hs_fall = ~bus.hsync & hs_q;
    assign w_vs_rise = bus.vsync & ~vs_q;
    // The pixel arriving with the hsync rising edge is column 0.
    assign w_pix_x   = w_hs_rise ? '0 : x_q;

    // Next column/row: saturating increments, vsync restart wins for y
    always_comb begin
        x_d = x_q;
        if (w_hs_rise)
            x_d = '0;
        if (bus.hsync && bus.pix_valid && (w_pix_x != '1))
            x_d = w_pix_x + 1'b1;
        y_d = y_q;
        if (w_hs_fall && (y_q != '1))
            y_d = y_q + 1'b1;
        if (w_vs_rise)
            y_d = '0;
    end

    // Edge-detect history and counter registers
    always_ff @(posedge clk) begin
        if (!nRst) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            hs_q <= bus.hsync;
            vs_q <= bus.vsync;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    // ------------------------------------------------------------------
    // Compare stage: threshold result and pixel coordinates registered
    // ------------------------------------------------------------------
    logic           p1_vld_q, p1_bright_q, p1_hfall_q;
    logic [X_W-1:0] p1_x_q;
    logic [Y_W-1:0] p1_y_q;

    // Register one pixel; anything coinciding with the frame edge is dropped
    always_ff @(posedge clk) begin
        if (!nRst) begin
            p1_vld_q    <= 1'b0;
            p1_bright_q <= 1'b0;
            p1_hfall_q  <= 1'b0;
            p1_x_q      <= '0;
            p1_y_q      <= '0;
        end else begin
            p1_vld_q    <= bus.hsync & bus.pix_valid & ~w_vs_rise;
            p1_bright_q <= (bus.pix >= bus.thresh);
            p1_hfall_q  <= w_hs_fall & ~w_vs_rise;
            p1_x_q      <= w_pix_x;
            p1_y_q      <= y_q;
        end
    end

    // ------------------------------------------------------------------
    // Run detection
    // ------------------------------------------------------------------
    logic           run_open_q, run_open_d;
    logic [X_W-1:0] run_xs_q, run_xs_d, run_xe_q, run_xe_d;
    logic [Y_W-1:0] run_y_q, run_y_d;
    logic [X_W:0]   w_run_len;
    logic           w_run_keep, w_run_close;

    assign w_run_len  = {1'b0, run_xe_q} - {1'b0, run_xs_q} + 1'b1;
    assign w_run_keep = (w_run_len >= C_MIN_RUN);

    // Open on a bright pixel, extend while bright, close on dark or line end
    always_comb begin
        run_open_d  = run_open_q;
        run_xs_d    = run_xs_q;
        run_xe_d    = run_xe_q;
        run_y_d     = run_y_q;
        w_run_close = 1'b0;
        if (p1_vld_q && p1_bright_q) begin
            if (!run_open_q) begin
                run_open_d = 1'b1;
                run_xs_d   = p1_x_q;
                run_xe_d   = p1_x_q;
                run_y_d    = p1_y_q;
            end else begin
                run_xe_d   = p1_x_q;
            end
        end else if ((p1_vld_q || p1_hfall_q) && run_open_q) begin
            run_open_d  = 1'b0;
            w_run_close = 1'b1;
        end
        // A run still open at the frame edge never reaches the merge stage.
        if (w_vs_rise) begin
            run_open_d  = 1'b0;
            w_run_close = 1'b0;
        end
    end

    logic           cl_vld_q;
    logic [X_W-1:0] cl_xs_q, cl_xe_q;
    logic [Y_W-1:0] cl_y_q;

    // Run state and the closed-run hand-off to the merge stage
    always_ff @(posedge clk) begin
        if (!nRst) begin
            run_open_q <= 1'b0;
            run_xs_q   <= '0;
            run_xe_q   <= '0;
            run_y_q    <= '0;
            cl_vld_q   <= 1'b0;
            cl_xs_q    <= '0;
            cl_xe_q    <= '0;
            cl_y_q     <= '0;
        end else begin
            run_open_q <= run_open_d;
            run_xs_q   <= run_xs_d;
            run_xe_q   <= run_xe_d;
            run_y_q    <= run_y_d;
            cl_vld_q   <= w_run_close & w_run_keep;
            cl_xs_q    <= run_xs_q;
            cl_xe_q    <= run_xe_q;
            cl_y_q     <= run_y_q;
        end
    end

    // ------------------------------------------------------------------
    // Working slots and merge
    // ------------------------------------------------------------------
    logic [N_SPOTS-1:0] sl_vld_q, sl_vld_d;
    logic [X_W-1:0]     sl_xmin_q [N_SPOTS];
    logic [X_W-1:0]     sl_xmin_d [N_SPOTS];
    logic [X_W-1:0]     sl_xmax_q [N_SPOTS];
    logic [X_W-1:0]     sl_xmax_d [N_SPOTS];
    logic [Y_W-1:0]     sl_ymin_q [N_SPOTS];
    logic [Y_W-1:0]     sl_ymin_d [N_SPOTS];
    logic [Y_W-1:0]     sl_ymax_q [N_SPOTS];
    logic [Y_W-1:0]     sl_ymax_d [N_SPOTS];
    logic [3:0]         wk_cnt_q, wk_cnt_d;
    logic               wk_ovf_q, wk_ovf_d;
`ifdef SPOT_AREA_EN
    logic [15:0]        sl_area_q [N_SPOTS];
    logic [15:0]        sl_area_d [N_SPOTS];
    logic [X_W:0]       w_cl_len;
    logic [16:0]        w_area_sum;
    assign w_cl_len = {1'b0, cl_xe_q} - {1'b0, cl_xs_q} + 1'b1;
`endif

    logic [N_SPOTS-1:0] w_match, w_hit_oh, w_free_oh;
    logic               w_hit, w_free;

    // Parallel adjacency test; pick lowest matching slot and lowest free slot
    always_comb begin
        w_match   = '0;
        w_hit_oh  = '0;
        w_free_oh = '0;
        w_hit     = 1'b0;
        w_free    = 1'b0;
        for (int i = 0; i < N_SPOTS; i++) begin
            w_match[i] = sl_vld_q[i]
                && (({1'b0, sl_ymax_q[i]} + 1'b1) >= {1'b0, cl_y_q})
                && ({1'b0, cl_xs_q} <= ({1'b0, sl_xmax_q[i]} + 1'b1))
                && (({1'b0, cl_xe_q} + 1'b1) >= {1'b0, sl_xmin_q[i]});
            if (w_match[i] && !w_hit) begin
                w_hit_oh[i] = 1'b1;
                w_hit       = 1'b1;
            end
            if (!sl_vld_q[i] && !w_free) begin
                w_free_oh[i] = 1'b1;
                w_free       = 1'b1;
            end
        end
    end

    // Slot update: frame-edge clear beats any merge landing in that cycle
    always_comb begin
        sl_vld_d  = sl_vld_q;
        sl_xmin_d = sl_xmin_q;
        sl_xmax_d = sl_xmax_q;
        sl_ymin_d = sl_ymin_q;
        sl_ymax_d = sl_ymax_q;
        wk_cnt_d  = wk_cnt_q;
        wk_ovf_d  = wk_ovf_q;
`ifdef SPOT_AREA_EN
        sl_area_d  = sl_area_q;
        w_area_sum = '0;
`endif
        if (w_vs_rise) begin
            sl_vld_d = '0;
            wk_cnt_d = '0;
            wk_ovf_d = 1'b0;
            for (int i = 0; i < N_SPOTS; i++) begin
                sl_xmin_d[i] = '0;
                sl_xmax_d[i] = '0;
                sl_ymin_d[i] = '0;
                sl_ymax_d[i] = '0;
`ifdef SPOT_AREA_EN
                sl_area_d[i] = '0;
`endif
            end
        end else if (cl_vld_q) begin
            if (w_hit) begin
                for (int i = 0; i < N_SPOTS; i++) begin
                    if (w_hit_oh[i]) begin
                        if (cl_xs_q < sl_xmin_q[i]) sl_xmin_d[i] = cl_xs_q;
                        if (cl_xe_q > sl_xmax_q[i]) sl_xmax_d[i] = cl_xe_q;
                        sl_ymax_d[i] = cl_y_q;
`ifdef SPOT_AREA_EN
                        w_area_sum   = {1'b0, sl_area_q[i]} + 17'(w_cl_len);
                        sl_area_d[i] = w_area_sum[16] ? 16'hFFFF : w_area_sum[15:0];
`endif
                    end
                end
            end else if (w_free) begin
                for (int i = 0; i < N_SPOTS; i++) begin
                    if (w_free_oh[i]) begin
                        sl_vld_d[i]  = 1'b1;
                        sl_xmin_d[i] = cl_xs_q;
                        sl_xmax_d[i] = cl_xe_q;
                        sl_ymin_d[i] = cl_y_q;
                        sl_ymax_d[i] = cl_y_q;
`ifdef SPOT_AREA_EN
                        w_area_sum   = 17'(w_cl_len);
                        sl_area_d[i] = w_area_sum[16] ? 16'hFFFF : w_area_sum[15:0];
`endif
                    end
                end
                wk_cnt_d = wk_cnt_q + 1'b1;
            end else begin
                wk_ovf_d = 1'b1;
            end
        end
    end

    // Working slot registers
    always_ff @(posedge clk) begin
        if (!nRst) begin
            sl_vld_q <= '0;
            wk_cnt_q <= '0;
            wk_ovf_q <= 1'b0;
            for (int i = 0; i < N_SPOTS; i++) begin
                sl_xmin_q[i] <= '0;
                sl_xmax_q[i] <= '0;
                sl_ymin_q[i] <= '0;
                sl_ymax_q[i] <= '0;
`ifdef SPOT_AREA_EN
                sl_area_q[i] <= '0;
`endif
            end
        end else begin
            sl_vld_q  <= sl_vld_d;
            sl_xmin_q <= sl_xmin_d;
            sl_xmax_q <= sl_xmax_d;
            sl_ymin_q <= sl_ymin_d;
            sl_ymax_q <= sl_ymax_d;
            wk_cnt_q  <= wk_cnt_d;
            wk_ovf_q  <= wk_ovf_d;
`ifdef SPOT_AREA_EN
            sl_area_q <= sl_area_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read bank, frame_done and readout
    // ------------------------------------------------------------------
    logic [X_W-1:0] bk_xmin_q [N_SPOTS];
    logic [X_W-1:0] bk_xmax_q [N_SPOTS];
    logic [Y_W-1:0] bk_ymin_q [N_SPOTS];
    logic [Y_W-1:0] bk_ymax_q [N_SPOTS];
`ifdef SPOT_AREA_EN
    logic [15:0]    bk_area_q [N_SPOTS];
`endif
    logic [3:0]     bk_cnt_q;
    logic           bk_ovf_q;
    logic           fd_pend_q, frame_done_q;
    logic [15:0]    rd_data_q, rd_data_d;

    // Bank copies the working set (pre-merge) at the frame edge only
    always_ff @(posedge clk) begin
        if (!nRst) begin
            bk_cnt_q <= '0;
            bk_ovf_q <= 1'b0;
            for (int i = 0; i < N_SPOTS; i++) begin
                bk_xmin_q[i] <= '0;
                bk_xmax_q[i] <= '0;
                bk_ymin_q[i] <= '0;
                bk_ymax_q[i] <= '0;
`ifdef SPOT_AREA_EN
                bk_area_q[i] <= '0;
`endif
            end
        end else if (w_vs_rise) begin
            bk_cnt_q  <= wk_cnt_q;
            bk_ovf_q  <= wk_ovf_q;
            bk_xmin_q <= sl_xmin_q;
            bk_xmax_q <= sl_xmax_q;
            bk_ymin_q <= sl_ymin_q;
            bk_ymax_q <= sl_ymax_q;
`ifdef SPOT_AREA_EN
            bk_area_q <= sl_area_q;
`endif
        end
    end

    // frame_done trails the bank update by one cycle
    always_ff @(posedge clk) begin
        if (!nRst) begin
            fd_pend_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fd_pend_q    <= w_vs_rise;
            frame_done_q <= fd_pend_q;
        end
    end

    // Field select; spots beyond the latched count read as zero
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if ((bus.rd_addr[5:3] == 3'(i)) && (4'(i) < bk_cnt_q)) begin
                case (bus.rd_addr[2:0])
                    3'd0:    rd_data_d = 16'(bk_xmin_q[i]);
                    3'd1:    rd_data_d = 16'(bk_xmax_q[i]);
                    3'd2:    rd_data_d = 16'(bk_ymin_q[i]);
                    3'd3:    rd_data_d = 16'(bk_ymax_q[i]);
`ifdef SPOT_AREA_EN
                    3'd4:    rd_data_d = bk_area_q[i];
`else
                    3'd4:    rd_data_d = '0;
`endif
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (!nRst) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.spot_cnt   = bk_cnt_q;
    assign bus.overflow   = bk_ovf_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spot_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spot_tracker
//  Brief    : Directed self-checking bench for spot_tracker (N_SPOTS=4,
//             MIN_RUN=2, 20-pixel lines).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spot_tracker;

`ifdef SPOT_AREA_EN
    localparam int C_AREA_ON = 1;
`else
    localparam int C_AREA_ON = 0;
`endif

    logic clk = 1'b0;
    logic nRst;
    int   total = 0;
    int   bad   = 0;
    int   fd_seen;

    always #5 clk = ~clk;

    spot_tracker_if #(.PIX_W(8)) bus ();

    spot_tracker #(
        .PIX_W(8), .X_W(10), .Y_W(10), .N_SPOTS(4), .MIN_RUN(2)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One 20-pixel line; bit x of m set means pixel x is bright.
    task automatic send_line(input logic [31:0] m);
        for (int x = 0; x < 20; x++) begin
            bus.hsync     = 1'b1;
            bus.pix_valid = 1'b1;
            bus.pix       = m[x] ? 8'd255 : 8'd0;
            @(negedge clk);
        end
        bus.hsync     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix       = 8'd0;
        repeat (4) @(negedge clk);
    endtask

    // vsync pulse plus frame_done timing checks
    task automatic end_frame(input string tag);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        chk({tag, "_fd_early"}, 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        chk({tag, "_fd_pulse"}, 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        chk({tag, "_fd_clear"}, 32'(bus.frame_done), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_rd(input string tag, input int idx, input int fld, input int exp);
        logic [2:0] a_i;
        logic [2:0] a_f;
        a_i = 3'(idx);
        a_f = 3'(fld);
        bus.rd_addr = {a_i, a_f};
        @(negedge clk);
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        nRst          = 1'b0;
        bus.vsync     = 1'b0;
        bus.hsync     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix       = 8'd0;
        bus.thresh    = 8'd200;
        bus.rd_addr   = 6'd0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_cnt", 32'(bus.spot_cnt), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_fd",  32'(bus.frame_done), 32'd0);
        chk("rst_rd",  32'(bus.rd_data), 32'd0);

        // Single spot: x=10..13, y=5..7
        for (int y = 0; y < 8; y++)
            send_line((y >= 5) ? 32'h0000_3C00 : 32'h0);
        end_frame("single");
        chk("single_cnt", 32'(bus.spot_cnt), 32'd1);
        chk("single_ovf", 32'(bus.overflow), 32'd0);
        chk_rd("single_xmin", 0, 0, 10);
        chk_rd("single_xmax", 0, 1, 13);
        chk_rd("single_ymin", 0, 2, 5);
        chk_rd("single_ymax", 0, 3, 7);
        chk_rd("single_area", 0, 4, (C_AREA_ON != 0) ? 12 : 0);
        chk_rd("single_idx1", 1, 0, 0);

        // Short run: one bright pixel is dropped
        send_line(32'h0000_0020);
        end_frame("short");
        chk("short_cnt", 32'(bus.spot_cnt), 32'd0);
        chk("short_ovf", 32'(bus.overflow), 32'd0);

        // Overflow: five separated 2x2 blocks
        send_line(32'h0003_3333);
        send_line(32'h0003_3333);
        end_frame("ovf");
        chk("ovf_cnt", 32'(bus.spot_cnt), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk_rd("ovf_s0_xmin", 0, 0, 0);
        chk_rd("ovf_s3_xmin", 3, 0, 12);
        chk_rd("ovf_s3_xmax", 3, 1, 13);
        chk_rd("ovf_s3_ymin", 3, 2, 0);
        chk_rd("ovf_s3_ymax", 3, 3, 1);
        chk_rd("ovf_s3_area", 3, 4, (C_AREA_ON != 0) ? 4 : 0);

        // Diagonal adjacency: 8..9 then 10..11
        send_line(32'h0000_0300);
        send_line(32'h0000_0C00);
        end_frame("diag");
        chk("diag_cnt", 32'(bus.spot_cnt), 32'd1);
        chk("diag_ovf", 32'(bus.overflow), 32'd0);
        chk_rd("diag_xmin", 0, 0, 8);
        chk_rd("diag_ymax", 0, 3, 1);
        chk_rd("diag_xmax", 0, 1, 11);

        // Bank stability: xmax of spot 0 holds while the next frame streams
        send_line(32'h0000_001C);
        chk("stab_line0", 32'(bus.rd_data), 32'd11);
        send_line(32'h0);
        chk("stab_line1", 32'(bus.rd_data), 32'd11);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        chk("stab_at_latch", 32'(bus.rd_data), 32'd11);
        chk("stab_cnt", 32'(bus.spot_cnt), 32'd1);
        @(negedge clk);
        chk("stab_new", 32'(bus.rd_data), 32'd4);
        chk("stab_fd", 32'(bus.frame_done), 32'd1);
        repeat (3) @(negedge clk);

        // Reset mid-frame
        send_line(32'h0000_3C00);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        chk("mrst_cnt", 32'(bus.spot_cnt), 32'd0);
        chk("mrst_ovf", 32'(bus.overflow), 32'd0);
        chk("mrst_rd",  32'(bus.rd_data), 32'd0);
        fd_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.frame_done) fd_seen++;
        end
        chk("mrst_no_fd", 32'(fd_seen), 32'd0);
        send_line(32'h0000_3C00);
        send_line(32'h0000_3C00);
        end_frame("post");
        chk("post_cnt", 32'(bus.spot_cnt), 32'd1);
        chk_rd("post_ymin", 0, 2, 0);
        chk_rd("post_ymax", 0, 3, 1);
        chk_rd("post_xmin", 0, 0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
